// File: rtl/cpu_run_pkg.sv
// cpu_run_pkg: shared definitions for the CPU run controller.
//   - state_t and ST_* : session FSM state encoding
//   - LOAD_TGT_*       : load_target selector values
//   - CYCLE_COUNT_WIDTH: width of the RUN cycle counter
package cpu_run_pkg;

    localparam int unsigned CYCLE_COUNT_WIDTH = 32;

    localparam logic LOAD_TGT_INST = 1'b0;
    localparam logic LOAD_TGT_DATA = 1'b1;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_LOAD = 3'd1;
    localparam state_t ST_HOLD = 3'd2;
    localparam state_t ST_RUN  = 3'd3;
    localparam state_t ST_DONE = 3'd4;

endpackage

// File: rtl/halt_detector.sv
// halt_detector: flags a core halt when the PC stays unchanged for HALT_REPEAT
// consecutive enabled cycles. The first enabled cycle has no previous PC.
//   clk, reset : clock, asynchronous active-high reset
//   enable     : high while the core is running; low clears all history
//   pc         : core program counter, sampled every enabled cycle
//   halt       : combinational pulse in the cycle the repeat count is reached
module halt_detector
    import cpu_run_pkg::*;
#(
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned HALT_REPEAT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [PC_WIDTH-1:0] pc,
    output logic                halt
);

    localparam int unsigned RW = (HALT_REPEAT > 1) ? $clog2(HALT_REPEAT) : 1;
    localparam logic [RW-1:0] REP_LAST = RW'(HALT_REPEAT - 1);

    logic [PC_WIDTH-1:0] prev_pc_q;
    logic                prev_valid_q;
    logic [RW-1:0]       rep_q;     // repeats already seen before this cycle
    logic                same_pc;

    assign same_pc = prev_valid_q && (pc == prev_pc_q);
    assign halt    = enable && same_pc && (rep_q == REP_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_pc_q    <= '0;
            prev_valid_q <= 1'b0;
            rep_q        <= '0;
        end else if (!enable) begin
            prev_pc_q    <= '0;
            prev_valid_q <= 1'b0;
            rep_q        <= '0;
        end else begin
            prev_pc_q    <= pc;
            prev_valid_q <= 1'b1;
            if (!same_pc) begin
                rep_q <= '0;
            end else if (rep_q != REP_LAST) begin
                rep_q <= rep_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_run_controller.sv
// cpu_run_controller: session controller for the single-cycle processor.
// Streams instruction/data images into memory, holds the core in reset for
// RESET_CYCLES, runs it under a MAX_CYCLES budget and reports halt/timeout.
//   clk, reset           : clock, asynchronous active-high reset (-> IDLE)
//   start                : session start pulse (IDLE/DONE only)
//   load_*               : load stream (valid/ready/target/data/last)
//   imem_*, dmem_*       : registered memory write ports
//   core_reset, core_pc  : processor reset out, processor PC in
//   busy, done, halted, timeout, load_overflow, cycle_count : status
module cpu_run_controller
    import cpu_run_pkg::*;
#(
    parameter int unsigned INST_WIDTH   = 32,
    parameter int unsigned INST_DEPTH   = 256,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DATA_DEPTH   = 256,
    parameter int unsigned PC_WIDTH     = 32,
    parameter int unsigned RESET_CYCLES = 1,
    parameter int unsigned MAX_CYCLES   = 25,
    parameter int unsigned HALT_REPEAT  = 4,
    localparam int unsigned LOAD_WIDTH  = (INST_WIDTH > DATA_WIDTH) ? INST_WIDTH : DATA_WIDTH,
    localparam int unsigned IA          = (INST_DEPTH > 1) ? $clog2(INST_DEPTH) : 1,
    localparam int unsigned DA          = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         load_valid,
    output logic                         load_ready,
    input  logic                         load_target,
    input  logic [LOAD_WIDTH-1:0]        load_data,
    input  logic                         load_last,
    output logic                         imem_we,
    output logic [IA-1:0]                imem_addr,
    output logic [INST_WIDTH-1:0]        imem_wdata,
    output logic                         dmem_we,
    output logic [DA-1:0]                dmem_addr,
    output logic [DATA_WIDTH-1:0]        dmem_wdata,
    output logic                         core_reset,
    input  logic [PC_WIDTH-1:0]          core_pc,
    output logic                         busy,
    output logic                         done,
    output logic                         halted,
    output logic                         timeout,
    output logic                         load_overflow,
    output logic [CYCLE_COUNT_WIDTH-1:0] cycle_count
);

    localparam int unsigned HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_CYCLES - 1);
    // Counters are one bit wider than the address so they can sit at DEPTH.
    localparam logic [IA:0] INST_FULL = (IA + 1)'(INST_DEPTH);
    localparam logic [DA:0] DATA_FULL = (DA + 1)'(DATA_DEPTH);
    localparam logic [CYCLE_COUNT_WIDTH-1:0] MAX_COUNT = CYCLE_COUNT_WIDTH'(MAX_CYCLES);

    state_t                         state_q, state_d;
    logic [IA:0]                    icnt_q, icnt_d;
    logic [DA:0]                    dcnt_q, dcnt_d;
    logic [HW-1:0]                  hold_q, hold_d;
    logic                           imem_we_q, imem_we_d;
    logic [IA-1:0]                  imem_addr_q, imem_addr_d;
    logic [INST_WIDTH-1:0]          imem_wdata_q, imem_wdata_d;
    logic                           dmem_we_q, dmem_we_d;
    logic [DA-1:0]                  dmem_addr_q, dmem_addr_d;
    logic [DATA_WIDTH-1:0]          dmem_wdata_q, dmem_wdata_d;
    logic                           core_reset_q, core_reset_d;
    logic                           done_q, done_d;
    logic                           halted_q, halted_d;
    logic                           timeout_q, timeout_d;
    logic                           ovf_q, ovf_d;
    logic [CYCLE_COUNT_WIDTH-1:0]   count_q, count_d;
    logic                           halt;

    halt_detector #(
        .PC_WIDTH    (PC_WIDTH),
        .HALT_REPEAT (HALT_REPEAT)
    ) u_halt_detector (
        .clk    (clk),
        .reset  (reset),
        .enable (state_q == ST_RUN),
        .pc     (core_pc),
        .halt   (halt)
    );

    always_comb begin
        state_d      = state_q;
        icnt_d       = icnt_q;
        dcnt_d       = dcnt_q;
        hold_d       = hold_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        dmem_we_d    = 1'b0;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        core_reset_d = core_reset_q;
        done_d       = done_q;
        halted_d     = halted_q;
        timeout_d    = timeout_q;
        ovf_d        = ovf_q;
        count_d      = count_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    icnt_d    = '0;
                    dcnt_d    = '0;
                    count_d   = '0;
                    done_d    = 1'b0;
                    halted_d  = 1'b0;
                    timeout_d = 1'b0;
                    ovf_d     = 1'b0;
                end
            end
            ST_LOAD: begin
                if (load_valid) begin
                    if (load_target == LOAD_TGT_INST) begin
                        if (icnt_q != INST_FULL) begin
                            imem_we_d    = 1'b1;
                            imem_addr_d  = icnt_q[IA-1:0];
                            imem_wdata_d = load_data[INST_WIDTH-1:0];
                            icnt_d       = icnt_q + 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end else begin
                        if (dcnt_q != DATA_FULL) begin
                            dmem_we_d    = 1'b1;
                            dmem_addr_d  = dcnt_q[DA-1:0];
                            dmem_wdata_d = load_data[DATA_WIDTH-1:0];
                            dcnt_d       = dcnt_q + 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                    if (load_last) begin
                        state_d = ST_HOLD;
                        hold_d  = '0;
                    end
                end
            end
            ST_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d      = ST_RUN;
                    core_reset_d = 1'b0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_RUN: begin
                count_d = count_q + 1'b1;
                // Halt takes priority over a timeout landing in the same cycle.
                if (halt) begin
                    state_d      = ST_DONE;
                    core_reset_d = 1'b1;
                    done_d       = 1'b1;
                    halted_d     = 1'b1;
                end else if (count_d == MAX_COUNT) begin
                    state_d      = ST_DONE;
                    core_reset_d = 1'b1;
                    done_d       = 1'b1;
                    timeout_d    = 1'b1;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                core_reset_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            icnt_q       <= '0;
            dcnt_q       <= '0;
            hold_q       <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            halted_q     <= 1'b0;
            timeout_q    <= 1'b0;
            ovf_q        <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            icnt_q       <= icnt_d;
            dcnt_q       <= dcnt_d;
            hold_q       <= hold_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            core_reset_q <= core_reset_d;
            done_q       <= done_d;
            halted_q     <= halted_d;
            timeout_q    <= timeout_d;
            ovf_q        <= ovf_d;
            count_q      <= count_d;
        end
    end

    assign load_ready    = (state_q == ST_LOAD);
    assign busy          = (state_q == ST_LOAD) || (state_q == ST_HOLD) || (state_q == ST_RUN);
    assign imem_we       = imem_we_q;
    assign imem_addr     = imem_addr_q;
    assign imem_wdata    = imem_wdata_q;
    assign dmem_we       = dmem_we_q;
    assign dmem_addr     = dmem_addr_q;
    assign dmem_wdata    = dmem_wdata_q;
    assign core_reset    = core_reset_q;
    assign done          = done_q;
    assign halted        = halted_q;
    assign timeout       = timeout_q;
    assign load_overflow = ovf_q;
    assign cycle_count   = count_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Testbench for cpu_run_controller: directed and randomized sessions checked
// against a queue-based reference model of loads and a run-outcome model.
module tb_cpu_run_controller;

    localparam int unsigned ID = 4;
    localparam int unsigned DD = 8;
    localparam int unsigned RC = 2;
    localparam int unsigned MC = 25;
    localparam int unsigned HR = 4;

    logic        clk = 1'b0;
    logic        reset, start, load_valid, load_target, load_last;
    logic [31:0] load_data, core_pc;
    logic        load_ready, imem_we, dmem_we, core_reset, busy;
    logic        done, halted, timeout, load_overflow;
    logic [1:0]  imem_addr;
    logic [2:0]  dmem_addr;
    logic [31:0] imem_wdata, dmem_wdata, cycle_count;

    always #5 clk = ~clk;

    cpu_run_controller #(
        .INST_WIDTH   (32),
        .INST_DEPTH   (ID),
        .DATA_WIDTH   (32),
        .DATA_DEPTH   (DD),
        .PC_WIDTH     (32),
        .RESET_CYCLES (RC),
        .MAX_CYCLES   (MC),
        .HALT_REPEAT  (HR)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .load_valid    (load_valid),
        .load_ready    (load_ready),
        .load_target   (load_target),
        .load_data     (load_data),
        .load_last     (load_last),
        .imem_we       (imem_we),
        .imem_addr     (imem_addr),
        .imem_wdata    (imem_wdata),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .core_reset    (core_reset),
        .core_pc       (core_pc),
        .busy          (busy),
        .done          (done),
        .halted        (halted),
        .timeout       (timeout),
        .load_overflow (load_overflow),
        .cycle_count   (cycle_count)
    );

    typedef struct {
        int unsigned addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic        tgt;
        logic [31:0] data;
        int unsigned gap;
    } beat_t;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    int unsigned n_fail  = 0;
    wr_t         iq[$];
    wr_t         dq[$];
    beat_t       beats[$];
    logic [31:0] pcs[MC];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and check any memory write against the expected stream.
    task automatic step();
        wr_t e;
        @(posedge clk);
        #1;
        if (imem_we) begin
            if (iq.size() == 0) begin
                chk("imem_spurious_we", 1, 0);
            end else begin
                e = iq.pop_front();
                chk("imem_addr", imem_addr, e.addr);
                chk("imem_wdata", imem_wdata, e.data);
            end
        end
        if (dmem_we) begin
            if (dq.size() == 0) begin
                chk("dmem_spurious_we", 1, 0);
            end else begin
                e = dq.pop_front();
                chk("dmem_addr", dmem_addr, e.addr);
                chk("dmem_wdata", dmem_wdata, e.data);
            end
        end
    endtask

    task automatic add_beat(input logic tgt, input logic [31:0] data, input int unsigned gap);
        beat_t b;
        b.tgt  = tgt;
        b.data = data;
        b.gap  = gap;
        beats.push_back(b);
    endtask

    // One full session: start, load beats[], hold, run on pcs[]. abort_at != 0
    // asserts reset during that RUN cycle instead of running to DONE.
    task automatic session(input int unsigned abort_at);
        int unsigned icnt, dcnt, rep, n_end;
        logic        ovf, exp_halt;
        wr_t         w;
        icnt = 0; dcnt = 0; ovf = 1'b0;
        iq.delete();
        dq.delete();

        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_ready", {load_ready, busy, core_reset}, 3'b111);
        chk("start_flags_clear", {done, halted, timeout, load_overflow}, 4'b0000);
        chk("start_count_clear", cycle_count, 0);

        foreach (beats[i]) begin
            load_valid = 1'b0;
            for (int g = 0; g < int'(beats[i].gap); g++) begin
                load_data   = $urandom;
                load_target = 1'($urandom_range(0, 1));
                load_last   = 1'($urandom_range(0, 1));
                start       = (g == 0);  // ignored while loading
                step();
                start       = 1'b0;
            end
            load_valid  = 1'b1;
            load_target = beats[i].tgt;
            load_data   = beats[i].data;
            load_last   = (i == beats.size() - 1);
            chk("load_ready_in_load", load_ready, 1);
            w.data = beats[i].data;
            if (!beats[i].tgt) begin
                if (icnt < ID) begin
                    w.addr = icnt;
                    iq.push_back(w);
                    icnt++;
                end else begin
                    ovf = 1'b1;
                end
            end else begin
                if (dcnt < DD) begin
                    w.addr = dcnt;
                    dq.push_back(w);
                    dcnt++;
                end else begin
                    ovf = 1'b1;
                end
            end
            step();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;

        for (int k = 1; k <= int'(RC); k++) begin
            chk("hold_state", {core_reset, busy, load_ready}, 3'b110);
            step();
        end
        chk("run_release", {core_reset, busy, load_ready}, 3'b010);
        chk("imem_writes_missing", iq.size(), 0);
        chk("dmem_writes_missing", dq.size(), 0);

        rep = 0; n_end = 0; exp_halt = 1'b0;
        for (int k = 1; k <= int'(MC) && n_end == 0; k++) begin
            if (k > 1 && pcs[k-1] == pcs[k-2]) rep++;
            else rep = 0;
            if (rep >= HR) begin
                n_end    = k;
                exp_halt = 1'b1;
            end else if (k == int'(MC)) begin
                n_end = k;
            end
        end

        for (int k = 1; k <= int'(n_end); k++) begin
            core_pc = pcs[k-1];
            if (k == int'(abort_at)) begin
                reset = 1'b1;
                #1;
                chk("abort_outputs",
                    {core_reset, load_ready, busy, imem_we, dmem_we,
                     done, halted, timeout, load_overflow}, 9'b100000000);
                chk("abort_count", cycle_count, 0);
                reset = 1'b0;
                step();
                chk("abort_idle", {core_reset, busy, done}, 3'b100);
                return;
            end
            start = (k == 3);  // ignored while running
            step();
            start = 1'b0;
            chk("run_count", cycle_count, k);
            if (k < int'(n_end)) chk("running", {core_reset, done, busy}, 3'b001);
        end
        chk("done_status", {done, halted, timeout, load_overflow, core_reset, busy},
            {1'b1, exp_halt, ~exp_halt, ovf, 1'b1, 1'b0});
        core_pc = $urandom;
        step();
        step();
        chk("done_hold", {done, halted, timeout, load_overflow}, {1'b1, exp_halt, ~exp_halt, ovf});
        chk("done_count_hold", cycle_count, n_end);
    endtask

    initial begin
        logic [31:0] pc;
        reset = 1'b1; start = 1'b0; load_valid = 1'b0; load_target = 1'b0;
        load_data = '0; load_last = 1'b0; core_pc = '0;
        #1;
        chk("reset_ctrl", {core_reset, load_ready, busy, imem_we, dmem_we}, 5'b10000);
        chk("reset_ports", {imem_addr, dmem_addr, imem_wdata, dmem_wdata}, 0);
        chk("reset_status", {done, halted, timeout, load_overflow, cycle_count}, 0);
        step();
        reset = 1'b0;
        step();
        step();
        chk("idle_stays", {core_reset, busy, load_ready}, 3'b100);

        // Four instruction beats, PC parks at 0x10 from RUN cycle 3 -> halt at 7.
        beats.delete();
        for (int i = 0; i < 4; i++) add_beat(1'b0, 32'h13 + i, 0);
        for (int k = 1; k <= int'(MC); k++) pcs[k-1] = (k == 1) ? 32'h0 : (k == 2) ? 32'h4 : 32'h10;
        session(0);
        chk("halt_case_count", cycle_count, 7);

        // Interleaved targets with stalls, PC always advancing -> timeout.
        beats.delete();
        add_beat(1'b0, 32'hA000_0001, 1);
        add_beat(1'b1, 32'hD000_0001, 2);
        add_beat(1'b0, 32'hA000_0002, 1);
        add_beat(1'b1, 32'hD000_0002, 1);
        for (int k = 1; k <= int'(MC); k++) pcs[k-1] = k * 4;
        session(0);
        chk("timeout_case", {timeout, halted, cycle_count}, {1'b1, 1'b0, 32'd25});

        // Six instruction beats into a 4-deep memory; halt lands on the last budget cycle.
        beats.delete();
        for (int i = 0; i < 6; i++) add_beat(1'b0, 32'hB000_0000 + i, i % 2);
        for (int k = 1; k <= int'(MC); k++) pcs[k-1] = (k <= 21) ? k * 4 : 21 * 4;
        session(0);
        chk("halt_beats_timeout", {halted, timeout, load_overflow}, 3'b101);

        // Reset during RUN cycle 5.
        beats.delete();
        add_beat(1'b0, 32'h1, 0);
        add_beat(1'b0, 32'h2, 0);
        for (int k = 1; k <= int'(MC); k++) pcs[k-1] = k * 8;
        session(5);

        // Randomized sessions.
        for (int s = 0; s < 8; s++) begin
            beats.delete();
            for (int i = 0; i < int'($urandom_range(1, 12)); i++)
                add_beat(1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 2));
            pc = $urandom & 32'hFFFF_FFFC;
            for (int k = 1; k <= int'(MC); k++) begin
                if (s % 3 == 0 || $urandom_range(0, 2) == 0) pc = pc + 4;
                pcs[k-1] = pc;
            end
            session(0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
